mem_access_unit: RTL
====================

# mem_access_unit

MEM-stage load/store unit placed directly upstream of the 4 KB word-addressed data memory in the pipelined MIPS core. Converts byte, halfword and word loads and stores into word accesses. Sub-word stores become a two-cycle read-modify-write, because the memory only writes whole words. Load data is extracted and sign/zero-extended before it returns to the pipeline, and misaligned accesses are reported.

## Interface
- `ADDR_W`, default 10: word-address width driven to data memory (byte address bits [ADDR_W+1:2]).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `valid_i` in 1: MEM stage holds a memory instruction this cycle.
- `mem_read_i` in 1: load.
- `mem_write_i` in 1: store. Write wins if both are set; `rdata_o` is then 0.
- `size_i` in 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
- `sign_ext_i` in 1: 1 = sign-extend sub-word load (LB/LH), 0 = zero-extend (LBU/LHU).
- `addr_i` in 32: byte address.
- `wdata_i` in 32: store data, right-justified.
- `rdata_o` out 32: extended load result.
- `stall_o` out 1: freeze PC/IF/ID/EX/MEM pipeline registers this cycle.
- `misalign_o` out 1: current access is misaligned; it is suppressed.
- `dm_a_o` out ADDR_W: word address to data memory.
- `dm_wd_o` out 32: write data to data memory.
- `dm_we_o` out 1: write enable to data memory.
- `dm_rd_i` in 32: combinational read data from data memory.

## Operation
- Byte lanes are little-endian: lane n = bits [8n+7:8n], selected by `addr_i[1:0]`.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00. A misaligned access has `dm_we_o`=0, `rdata_o`=0 and `misalign_o`=1.
- FSM states:
  - IDLE:
    - Load: `rdata_o` = selected lane(s) of `dm_rd_i`, extended to 32 bits. No stall.
    - Word store: `dm_we_o`=1, `dm_wd_o`=`wdata_i`. No stall.
    - Aligned byte/half store: `dm_we_o`=0 and `stall_o`=1. `dm_rd_i` is merged with the low byte or half of `wdata_i` in the addressed lane(s). The merged word and `dm_a_o` are latched. Next state is MERGE.
  - MERGE:
    - `dm_a_o` = latched address, `dm_wd_o` = merged word, `dm_we_o`=1, `stall_o`=0.
    - Inputs are ignored. Next state is always IDLE.
- While `stall_o`=1, the upstream stage holds every input stable. The unit still latches internally, so the values of held inputs in MERGE do not matter.
- `valid_i`=0 in IDLE: `dm_we_o`=0, `stall_o`=0, `rdata_o`=0, `misalign_o`=0.

## Timing
- Loads, word stores and misaligned accesses take 1 cycle. Sub-word stores take 2 cycles, with exactly one stall cycle.
- `stall_o` and `misalign_o` are combinational from inputs and state. `rdata_o` is combinational from `dm_rd_i`; the unit adds no load latency.
- Registered state is the FSM, the latched word address and the merged word. Reset values are IDLE and zeros.
- Outputs during reset: `dm_we_o`=0, `stall_o`=0, `misalign_o`=0, `rdata_o`=0, `dm_wd_o`=0, `dm_a_o`=0.
- Reset asserted in MERGE returns the FSM to IDLE immediately. The pending write is dropped and memory is left unmodified.
- A store issued in the cycle after MERGE (back-to-back sub-word stores) starts a new read-modify-write from IDLE. Its read sees the previous write, because memory writes at the MERGE edge.

## Configuration
- `MAU_MISALIGN_TRAP_EN` defined: misalignment is detected and suppressed as described above.
- `MAU_MISALIGN_TRAP_EN` undefined:
  - `misalign_o` is tied 0.
  - Halfword addresses ignore addr[0] and word addresses ignore addr[1:0]; the access proceeds on the force-aligned address.

## Structure
- Package `mau_pkg` holds:
  - size encodings `MAU_SZ_BYTE/HALF/WORD`;
  - FSM enum `mau_state_t` {MAU_IDLE, MAU_MERGE};
  - lane-width constants.
- Sub-module `mau_lane_ext` is the combinational lane select and sign/zero extension for loads. `mau_lane_ext` is instantiated once. The store merge stays inline.

## Test plan
- Memory word 0x100 = 0x8877_6655.
  - LB at 0x403 returns `rdata_o` = 0xFFFF_FF88.
  - LBU at 0x403 returns 0x0000_0088.
  - LHU at 0x400 returns 0x0000_6655.
- SB of `wdata_i` 0x0000_00AA at 0x401 over word 0x1122_3344:
  - Cycle 1: `stall_o`=1, `dm_we_o`=0.
  - Cycle 2: `dm_we_o`=1, `dm_wd_o`=0x1122_AA44.
  - Memory afterwards = 0x1122_AA44.
- SW 0xDEAD_BEEF at 0x008: one cycle, `dm_we_o`=1, `dm_a_o`=2, no stall.
- With `MAU_MISALIGN_TRAP_EN`:
  - SH at 0x003: `misalign_o`=1, `dm_we_o`=0, memory unchanged.
  - LW at 0x002: `rdata_o`=0.
- Without the macro: LW at 0x006 reads word address 1.
- SB issued, then `rst_n` pulled low during MERGE: FSM returns to IDLE, `dm_we_o` never rises, memory unchanged.
- Two back-to-back SBs, 0x11 to 0x400 and 0x22 to 0x401: 2 stall cycles total; final word low half = 0x2211.

Source files
------------

// File: rtl/mau_pkg.sv
// mau_pkg: shared types and constants for the MEM-stage load/store unit.
//   - size encodings MAU_SZ_BYTE/HALF/WORD (2'b11 is reserved and behaves as word)
//   - FSM state type mau_state_t
//   - lane geometry constants
// Used by: mem_access_unit, mau_lane_ext.
package mau_pkg;

    localparam int LANE_W    = 8;
    localparam int NUM_LANES = 4;
    localparam int DATA_W    = LANE_W * NUM_LANES;

    localparam logic [1:0] MAU_SZ_BYTE = 2'b00;
    localparam logic [1:0] MAU_SZ_HALF = 2'b01;
    localparam logic [1:0] MAU_SZ_WORD = 2'b10;

    typedef enum logic {
        MAU_IDLE  = 1'b0,
        MAU_MERGE = 1'b1
    } mau_state_t;

    // Word covers both 2'b10 and the reserved 2'b11 encoding.
    function automatic logic mau_is_word(input logic [1:0] size);
        return size[1];
    endfunction

endpackage

// File: rtl/mau_lane_ext.sv
// mau_lane_ext: combinational load-data lane select plus sign/zero extension.
// Ports:
//   word_i     in  32  full word read from data memory
//   off_i      in  2   byte offset of the access (already force-aligned if needed)
//   size_i     in  2   access size (byte/half/word)
//   sign_ext_i in  1   1 = sign-extend sub-word result, 0 = zero-extend
//   data_o     out 32  extended result
module mau_lane_ext
    import mau_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    output logic [DATA_W-1:0] data_o
);

    logic [NUM_LANES-1:0][LANE_W-1:0] lanes;
    logic [LANE_W-1:0]                b;
    logic [2*LANE_W-1:0]              h;

    assign lanes = word_i;

    always_comb begin
        b      = lanes[off_i];
        // Half-word select only looks at offset bit 1; bit 0 is either
        // zero (aligned) or ignored (force-aligned).
        h      = off_i[1] ? {lanes[3], lanes[2]} : {lanes[1], lanes[0]};
        data_o = word_i;
        if (size_i == MAU_SZ_BYTE)
            data_o = {{(DATA_W-LANE_W){sign_ext_i & b[LANE_W-1]}}, b};
        else if (size_i == MAU_SZ_HALF)
            data_o = {{(DATA_W-2*LANE_W){sign_ext_i & h[2*LANE_W-1]}}, h};
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-addressed
// data memory. Loads are lane-selected and extended combinationally; word
// stores write straight through; byte/half stores run a two-cycle
// read-modify-write (IDLE: read+merge+stall, MERGE: write merged word).
//
// Build option: MAU_MISALIGN_TRAP_EN
//   defined   - misaligned half/word accesses are flagged on misalign_o and
//               suppressed (no write, rdata_o = 0).
//   undefined - misalign_o = 0; half/word offsets are force-aligned.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   valid_i            MEM stage holds a memory op
//   mem_read_i         load
//   mem_write_i        store (wins over load)
//   size_i             00 byte, 01 half, 1x word
//   sign_ext_i         sign- vs zero-extend sub-word loads
//   addr_i             byte address
//   wdata_i            right-justified store data
//   rdata_o            extended load data
//   stall_o            freeze upstream pipeline this cycle
//   misalign_o         access misaligned and suppressed
//   dm_a_o/dm_wd_o/dm_we_o  data memory word address / write data / write enable
//   dm_rd_i            combinational data memory read data
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [1:0]        size_i,
    input  logic              sign_ext_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] dm_a_o,
    output logic [31:0]       dm_wd_o,
    output logic              dm_we_o,
    input  logic [31:0]       dm_rd_i
);

    mau_state_t state, nstate;
    logic [ADDR_W-1:0] lat_a;
    logic [DATA_W-1:0] lat_wd;

    logic       is_acc, is_st, is_ld, sz_word, sz_half, mis, rmw_start;
    logic [1:0] off;
    logic [DATA_W-1:0] ld_data;
    logic [NUM_LANES-1:0][LANE_W-1:0] mrg;

    assign is_acc  = valid_i & (mem_read_i | mem_write_i);
    assign is_st   = valid_i & mem_write_i;
    assign is_ld   = valid_i & mem_read_i & ~mem_write_i;
    assign sz_word = mau_is_word(size_i);
    assign sz_half = (size_i == MAU_SZ_HALF);

`ifdef MAU_MISALIGN_TRAP_EN
    assign mis = is_acc & ((sz_half & addr_i[0]) | (sz_word & (addr_i[1:0] != 2'b00)));
    assign off = addr_i[1:0];
`else
    assign mis = 1'b0;
    assign off = sz_word ? 2'b00 : (sz_half ? {addr_i[1], 1'b0} : addr_i[1:0]);
`endif

    assign rmw_start = (state == MAU_IDLE) & is_st & ~sz_word & ~mis;

    // Store merge: overwrite the addressed lane(s) of the current word.
    always_comb begin
        mrg = dm_rd_i;
        if (sz_half) begin
            mrg[{off[1], 1'b0}] = wdata_i[7:0];
            mrg[{off[1], 1'b1}] = wdata_i[15:8];
        end else begin
            mrg[off] = wdata_i[7:0];
        end
    end

    mau_lane_ext u_ext (
        .word_i     (dm_rd_i),
        .off_i      (off),
        .size_i     (size_i),
        .sign_ext_i (sign_ext_i),
        .data_o     (ld_data)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= MAU_IDLE;
        else        state <= nstate;
    end

    // RMW latch: address and merged word captured in the stall cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_a  <= '0;
            lat_wd <= '0;
        end else if (rmw_start) begin
            lat_a  <= addr_i[ADDR_W+1:2];
            lat_wd <= mrg;
        end
    end

    // Next state
    always_comb begin
        nstate = state;
        case (state)
            MAU_IDLE:  nstate = rmw_start ? MAU_MERGE : MAU_IDLE;
            MAU_MERGE: nstate = MAU_IDLE;
            default:   nstate = MAU_IDLE;
        endcase
    end

    // Outputs. Everything is forced low while reset is held so a reset
    // landing in MERGE cannot leak the pending write to memory.
    always_comb begin
        rdata_o    = '0;
        stall_o    = 1'b0;
        misalign_o = 1'b0;
        dm_a_o     = '0;
        dm_wd_o    = '0;
        dm_we_o    = 1'b0;
        if (rst_n) begin
            case (state)
                MAU_IDLE: begin
                    dm_a_o     = addr_i[ADDR_W+1:2];
                    misalign_o = mis;
                    if (is_st && !mis) begin
                        if (sz_word) begin
                            dm_we_o = 1'b1;
                            dm_wd_o = wdata_i;
                        end else begin
                            stall_o = 1'b1;
                        end
                    end
                    if (is_ld && !mis) rdata_o = ld_data;
                end
                MAU_MERGE: begin
                    dm_a_o  = lat_a;
                    dm_wd_o = lat_wd;
                    dm_we_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
